// File: rtl/game_key_if.sv
// Keyboard-to-core signal bundle: PS/2 byte strobe and win level in, cursor and commands out.
interface game_key_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       win;
  logic [5:0] cursor;
  logic       game_area;
  logic       left;
  logic       right;
  logic       retract;
  logic       retry;

  modport master (
    output scan_code, scan_valid, win,
    input  cursor, game_area, left, right, retract, retry
  );

  modport slave (
    input  scan_code, scan_valid, win,
    output cursor, game_area, left, right, retract, retry
  );
endinterface

// File: rtl/game_key_input.sv
// PS/2 set-2 decoder for the Sokoban core: prefix tracking, 8x8 cursor moves and
// single-cycle command pulses with per-key typematic suppression.
module game_key_input (
  input  logic       clk,
  input  logic       reset,
  game_key_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBrk   = 8'hF0;
  localparam logic [7:0] CodeUp    = 8'h75;
  localparam logic [7:0] CodeDown  = 8'h72;
  localparam logic [7:0] CodeLeft  = 8'h6B;
  localparam logic [7:0] CodeRight = 8'h74;
  localparam logic [7:0] CodeEnter = 8'h5A;
  localparam logic [7:0] CodeN     = 8'h31;
  localparam logic [7:0] CodeBksp  = 8'h66;
  localparam logic [7:0] CodeR     = 8'h2D;
  localparam logic [7:0] CodeEsc   = 8'h76;

  state_e     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       area_q, area_d;
  // Bit order {retry, retract, right, left}, shared by pulses and held flags.
  logic [3:0] pulse_q, pulse_d;
  logic [3:0] held_q, held_d;

  logic       plain_make, plain_brk, ext_make;
  logic       cmd_hit;
  logic [1:0] cmd_sel;

  always_comb begin
    cmd_hit = 1'b1;
    cmd_sel = 2'd0;
    case (bus.scan_code)
      CodeEnter: cmd_sel = 2'd0;
      CodeN:     cmd_sel = 2'd1;
      CodeBksp:  cmd_sel = 2'd2;
      CodeR:     cmd_sel = 2'd3;
      default:   cmd_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    plain_make = 1'b0;
    plain_brk  = 1'b0;
    ext_make   = 1'b0;
    if (bus.scan_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.scan_code == CodeExt) begin
            state_d = StExt;
          end else if (bus.scan_code == CodeBrk) begin
            state_d = StBrk;
          end else begin
            plain_make = 1'b1;
          end
        end
        StExt: begin
          if (bus.scan_code == CodeBrk) begin
            state_d = StExtBrk;
          end else if (bus.scan_code != CodeExt) begin
            ext_make = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          plain_brk = 1'b1;
          state_d   = StIdle;
        end
        // Extended breaks carry no meaning here; just return to idle.
        StExtBrk: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    area_d  = area_q;
    pulse_d = 4'b0000;
    held_d  = held_q;

    if (ext_make) begin
      case (bus.scan_code)
        CodeUp: begin
          area_d = 1'b1;
          if (row_q != 3'd0) row_d = row_q - 3'd1;
        end
        CodeDown: begin
          area_d = 1'b1;
          if (row_q != 3'd7) row_d = row_q + 3'd1;
        end
        CodeLeft: begin
          area_d = 1'b1;
          if (col_q != 3'd0) col_d = col_q - 3'd1;
        end
        CodeRight: begin
          area_d = 1'b1;
          if (col_q != 3'd7) col_d = col_q + 3'd1;
        end
        default: ;
      endcase
    end

    if (plain_make && cmd_hit && !held_q[cmd_sel]) begin
      held_d[cmd_sel] = 1'b1;
      // A gated Enter still latches its held flag so its repeats stay silent.
      if (cmd_sel != 2'd0 || (area_q && !bus.win)) pulse_d[cmd_sel] = 1'b1;
    end

    if (plain_make && bus.scan_code == CodeEsc) area_d = 1'b0;

    if (plain_brk && cmd_hit) held_d[cmd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      area_q  <= 1'b0;
      pulse_q <= 4'b0000;
      held_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      area_q  <= area_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign bus.cursor    = {row_q, col_q};
  assign bus.game_area = area_q;
  assign bus.left      = pulse_q[0];
  assign bus.right     = pulse_q[1];
  assign bus.retract   = pulse_q[2];
  assign bus.retry     = pulse_q[3];

endmodule

// File: tb/tb_game_key_input.sv
// Directed test-plan steps followed by random byte streams, checked every cycle
// against a prefix/held-key model of the keyboard front end.
module tb_game_key_input;

  logic clk = 1'b0;
  logic reset;
  game_key_if bus ();

  game_key_input dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: pending prefixes, board position, area level, per-code held table.
  bit       m_ext, m_brk;
  int       m_row, m_col;
  bit       m_area;
  bit       m_held [256];
  bit [3:0] m_pulse;  // {retry, retract, right, left}

  logic [7:0] codes [13] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A,
                             8'h31, 8'h66, 8'h2D, 8'h76, 8'hE1, 8'h1C};

  function automatic logic [10:0] obs();
    return {bus.cursor, bus.game_area, bus.retry, bus.retract, bus.right, bus.left};
  endfunction

  function automatic logic [10:0] expv();
    return {6'(m_row * 8 + m_col), m_area, m_pulse};
  endfunction

  task automatic check(input string tag, input logic [10:0] o, input logic [10:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_cursor(input string tag, input int v);
    checks++;
    assert (bus.cursor === 6'(v)) else begin
      errors++;
      $error("FAIL %s cursor observed=%0d expected=%0d", tag, bus.cursor, v);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_row = 0; m_col = 0; m_area = 0; m_pulse = '0;
    for (int i = 0; i < 256; i++) m_held[i] = 0;
  endtask

  task automatic model_byte(input logic [7:0] c, input logic w);
    m_pulse = '0;
    if (!m_brk && c == 8'hE0) begin
      m_ext = 1;
      return;
    end
    if (!m_brk && c == 8'hF0) begin
      m_brk = 1;
      return;
    end
    if (m_ext && !m_brk) begin
      case (c)
        8'h75: begin m_row = (m_row > 0) ? m_row - 1 : 0; m_area = 1; end
        8'h72: begin m_row = (m_row < 7) ? m_row + 1 : 7; m_area = 1; end
        8'h6B: begin m_col = (m_col > 0) ? m_col - 1 : 0; m_area = 1; end
        8'h74: begin m_col = (m_col < 7) ? m_col + 1 : 7; m_area = 1; end
        default: ;
      endcase
    end else if (!m_ext && !m_brk) begin
      if ((c == 8'h5A || c == 8'h31 || c == 8'h66 || c == 8'h2D) && !m_held[c]) begin
        m_held[c] = 1;
        if (c == 8'h5A) m_pulse[0] = m_area && !w;
        if (c == 8'h31) m_pulse[1] = 1;
        if (c == 8'h66) m_pulse[2] = 1;
        if (c == 8'h2D) m_pulse[3] = 1;
      end
      if (c == 8'h76) m_area = 0;
    end else if (!m_ext && m_brk) begin
      m_held[c] = 0;
    end
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic send(input logic [7:0] c, input logic w);
    @(negedge clk);
    bus.scan_code  = c;
    bus.scan_valid = 1'b1;
    bus.win        = w;
    model_byte(c, w);
    @(posedge clk);
    #1;
    check("byte", obs(), expv());
    bus.scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.scan_valid = 1'b0;
      bus.scan_code  = 8'($urandom);
      m_pulse        = '0;
      @(posedge clk);
      #1;
      check("idle", obs(), expv());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.scan_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("reset", obs(), expv());
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    bus.win        = 1'b0;
    model_reset();
    do_reset();
    check("reset_const", obs(), 11'd0);

    // Cursor moves to row 2 col 3.
    repeat (3) begin send(8'hE0, 0); send(8'h74, 0); end
    repeat (2) begin send(8'hE0, 0); send(8'h72, 0); end
    check_cursor("move_19", 19);
    idle(1);

    // Saturation at the top-left corner and at column 7.
    do_reset();
    send(8'hE0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'h6B, 0);
    check_cursor("clamp_0", 0);
    repeat (9) begin send(8'hE0, 0); send(8'h74, 0); end
    check_cursor("clamp_7", 7);

    // Enter with typematic repeat, then release and press again.
    send(8'h5A, 0); send(8'h5A, 0); send(8'h5A, 0);
    send(8'hF0, 0); send(8'h5A, 0); send(8'h5A, 0);
    idle(2);

    // Win gates Enter; Esc leaves the board; Backspace retracts.
    send(8'hF0, 0); send(8'h5A, 0);
    send(8'h5A, 1);
    send(8'h76, 1); send(8'h66, 0);
    check_cursor("esc_keep", 7);
    idle(1);

    // Reset mid-prefix discards the E0.
    do_reset();
    send(8'hE0, 0);
    do_reset();
    send(8'h74, 0);
    check_cursor("prefix_drop", 0);

    // Retry and right; extended break changes nothing.
    send(8'h2D, 0); send(8'hF0, 0); send(8'h2D, 0); send(8'h31, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h74, 0);
    idle(1);

    // Random streams over the interesting code set.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 14) idle(1);
      else send(codes[$urandom_range(0, 12)], ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
